// File: rtl/transfer_id_tracker.sv
// Per-channel transfer ID allocator with out-of-order retirement tracking.
// completed_o walks the contiguous prefix of retired IDs, at most one ID per channel per cycle.
module transfer_id_tracker #(
  parameter int NUM_CHANNELS    = 2,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CHAN_WIDTH      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             issue_valid_i,
  input  logic [CHAN_WIDTH-1:0]            issue_chan_i,
  output logic                             issue_ready_o,
  output logic [ID_WIDTH-1:0]              issue_id_o,
  input  logic                             retire_valid_i,
  input  logic [CHAN_WIDTH-1:0]            retire_chan_i,
  input  logic [ID_WIDTH-1:0]              retire_id_i,
  output logic                             retire_err_o,
  output logic [NUM_CHANNELS*ID_WIDTH-1:0] next_o,
  output logic [NUM_CHANNELS*ID_WIDTH-1:0] completed_o,
  output logic [NUM_CHANNELS-1:0]          idle_o
);

  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH-1:0] ID_ONE     = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0] ID_MAX_OUT = ID_WIDTH'(MAX_OUTSTANDING);

  logic [ID_WIDTH-1:0]        next_q      [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]        next_d      [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]        completed_q [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]        completed_d [NUM_CHANNELS];
  logic [MAX_OUTSTANDING-1:0] bitmap_q    [NUM_CHANNELS];
  logic [MAX_OUTSTANDING-1:0] bitmap_d    [NUM_CHANNELS];
  logic                       err_q;
  logic                       err_d;

  logic [ID_WIDTH-1:0]        outstanding [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]        adv_id      [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]        offset      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    full;
  logic [NUM_CHANNELS-1:0]    retire_acc;
  logic [NUM_CHANNELS-1:0]    bypass;
  logic [NUM_CHANNELS-1:0]    advance;
  logic                       issue_fire;

  // Occupancy is derived purely from registered pointers, so issue_ready_o
  // never depends combinationally on the retire inputs.
  always_comb begin
    full   = '0;
    idle_o = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      outstanding[c] = next_q[c] - ID_ONE - completed_q[c];
      full[c]        = (outstanding[c] == ID_MAX_OUT);
      idle_o[c]      = (outstanding[c] == '0);
      next_o[c*ID_WIDTH +: ID_WIDTH]      = next_q[c];
      completed_o[c*ID_WIDTH +: ID_WIDTH] = completed_q[c];
    end
  end

  // An out-of-range channel matches no entry and leaves ready low.
  always_comb begin
    issue_ready_o = 1'b0;
    issue_id_o    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (issue_chan_i == CHAN_WIDTH'(c)) begin
        issue_ready_o = !full[c];
        issue_id_o    = next_q[c];
      end
    end
  end

  assign issue_fire = issue_valid_i && issue_ready_o;

  always_comb begin
    retire_acc = '0;
    bypass     = '0;
    advance    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      next_d[c]      = next_q[c];
      completed_d[c] = completed_q[c];
      bitmap_d[c]    = bitmap_q[c];
      adv_id[c]      = completed_q[c] + ID_ONE;
      offset[c]      = retire_id_i - adv_id[c];

      retire_acc[c] = retire_valid_i && (retire_chan_i == CHAN_WIDTH'(c))
                      && (offset[c] < outstanding[c])
                      && !bitmap_q[c][retire_id_i[IDX_W-1:0]];
      // The window is at most MAX_OUTSTANDING wide, so a retiring ID can only
      // alias bit adv_id when it is adv_id itself; that case bypasses the bitmap.
      bypass[c]  = retire_acc[c] && (retire_id_i == adv_id[c]);
      advance[c] = bitmap_q[c][adv_id[c][IDX_W-1:0]] || bypass[c];

      if (retire_acc[c] && !bypass[c]) begin
        bitmap_d[c][retire_id_i[IDX_W-1:0]] = 1'b1;
      end
      if (advance[c]) begin
        completed_d[c]                    = adv_id[c];
        bitmap_d[c][adv_id[c][IDX_W-1:0]] = 1'b0;
      end
      if (issue_fire && (issue_chan_i == CHAN_WIDTH'(c))) begin
        next_d[c] = next_q[c] + ID_ONE;
      end
    end
    err_d = retire_valid_i && !(|retire_acc);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        next_q[c]      <= ID_ONE;
        completed_q[c] <= '0;
        bitmap_q[c]    <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        next_q[c]      <= next_d[c];
        completed_q[c] <= completed_d[c];
        bitmap_q[c]    <= bitmap_d[c];
      end
      err_q <= err_d;
    end
  end

  assign retire_err_o = err_q;

endmodule

// File: tb/tb_transfer_id_tracker.sv
// Scoreboard bench for transfer_id_tracker: a default 2-channel instance and a
// 3-channel, 4-bit-ID instance driven together against a set-based reference model.
module tb_transfer_id_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ready, a_rv, a_err;
  logic [0:0]  a_ic, a_rc;
  logic [7:0]  a_iid, a_rid;
  logic [15:0] a_next, a_comp;
  logic [1:0]  a_idle;

  logic        b_iv, b_ready, b_rv, b_err;
  logic [1:0]  b_ic, b_rc;
  logic [3:0]  b_iid, b_rid;
  logic [11:0] b_next, b_comp;
  logic [2:0]  b_idle;

  transfer_id_tracker u_a (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(a_iv), .issue_chan_i(a_ic), .issue_ready_o(a_ready), .issue_id_o(a_iid),
    .retire_valid_i(a_rv), .retire_chan_i(a_rc), .retire_id_i(a_rid), .retire_err_o(a_err),
    .next_o(a_next), .completed_o(a_comp), .idle_o(a_idle)
  );

  transfer_id_tracker #(.NUM_CHANNELS(3), .ID_WIDTH(4), .MAX_OUTSTANDING(4)) u_b (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(b_iv), .issue_chan_i(b_ic), .issue_ready_o(b_ready), .issue_id_o(b_iid),
    .retire_valid_i(b_rv), .retire_chan_i(b_rc), .retire_id_i(b_rid), .retire_err_o(b_err),
    .next_o(b_next), .completed_o(b_comp), .idle_o(b_idle)
  );

  typedef struct packed {
    logic        a_ready;
    logic [7:0]  a_iid;
    logic        a_err;
    logic [15:0] a_next;
    logic [15:0] a_comp;
    logic [1:0]  a_idle;
    logic        b_chk_id;
    logic        b_ready;
    logic [3:0]  b_iid;
    logic        b_err;
    logic [11:0] b_next;
    logic [11:0] b_comp;
    logic [2:0]  b_idle;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: per channel a next counter, a completed pointer and the
  // set of retired-but-not-yet-completed IDs, indexed by the full ID value.
  int m_next [2][3];
  int m_comp [2][3];
  bit m_done [2][3][256];
  bit m_err  [2];

  int in_iv[2], in_ic[2], in_rv[2], in_rc[2], in_rid[2];
  bit rst_in;

  function automatic int id_mod(input int k);  return (k == 0) ? 256 : 16; endfunction
  function automatic int max_out(input int k); return (k == 0) ? 8 : 4;    endfunction
  function automatic int n_chan(input int k);  return (k == 0) ? 2 : 3;    endfunction
  function automatic int wrapk(input int k, input int x);
    return ((x % id_mod(k)) + id_mod(k)) % id_mod(k);
  endfunction
  function automatic int outst(input int k, input int c);
    return wrapk(k, m_next[k][c] - 1 - m_comp[k][c]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_next[k][c] = 1;
        m_comp[k][c] = 0;
        for (int i = 0; i < 256; i++) m_done[k][c][i] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int k);
    int cr, rid, n;
    bit acc, byp, fire;
    fire = 1'b0;
    if (in_iv[k] != 0 && in_ic[k] < n_chan(k)) fire = (outst(k, in_ic[k]) < max_out(k));
    acc = 1'b0;
    cr  = in_rc[k];
    rid = wrapk(k, in_rid[k]);
    if (in_rv[k] != 0 && cr < n_chan(k))
      acc = (wrapk(k, rid - m_comp[k][cr] - 1) < outst(k, cr)) && !m_done[k][cr][rid];
    for (int c = 0; c < n_chan(k); c++) begin
      n   = wrapk(k, m_comp[k][c] + 1);
      byp = acc && (c == cr) && (rid == n);
      if (m_done[k][c][n] || byp) begin
        m_comp[k][c]    = n;
        m_done[k][c][n] = 1'b0;
      end
      if (acc && (c == cr) && !byp) m_done[k][c][rid] = 1'b1;
    end
    if (fire) m_next[k][in_ic[k]] = wrapk(k, m_next[k][in_ic[k]] + 1);
    m_err[k] = (in_rv[k] != 0) && !acc;
  endtask

  function automatic snap_t predict();
    snap_t s;
    s         = '0;
    s.a_ready = (outst(0, in_ic[0]) < 8);
    s.a_iid   = 8'(m_next[0][in_ic[0]]);
    s.a_err   = m_err[0];
    for (int c = 0; c < 2; c++) begin
      s.a_next[c*8 +: 8] = 8'(m_next[0][c]);
      s.a_comp[c*8 +: 8] = 8'(m_comp[0][c]);
      s.a_idle[c]        = (outst(0, c) == 0);
    end
    s.b_chk_id = (in_ic[1] < 3);
    if (s.b_chk_id) begin
      s.b_ready = (outst(1, in_ic[1]) < 4);
      s.b_iid   = 4'(m_next[1][in_ic[1]]);
    end
    s.b_err = m_err[1];
    for (int c = 0; c < 3; c++) begin
      s.b_next[c*4 +: 4] = 4'(m_next[1][c]);
      s.b_comp[c*4 +: 4] = 4'(m_comp[1][c]);
      s.b_idle[c]        = (outst(1, c) == 0);
    end
    return s;
  endfunction

  task automatic apply_inputs();
    rst   = rst_in;
    a_iv  = (in_iv[0] != 0); a_ic = 1'(in_ic[0]);
    a_rv  = (in_rv[0] != 0); a_rc = 1'(in_rc[0]); a_rid = 8'(in_rid[0]);
    b_iv  = (in_iv[1] != 0); b_ic = 2'(in_ic[1]);
    b_rv  = (in_rv[1] != 0); b_rc = 2'(in_rc[1]); b_rid = 4'(in_rid[1]);
  endtask

  task automatic clear_in();
    for (int k = 0; k < 2; k++) begin
      in_iv[k] = 0; in_ic[k] = 0; in_rv[k] = 0; in_rc[k] = 0; in_rid[k] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    apply_inputs();
    if (rst_in) model_reset();
    exp_q.push_back(predict());
    if (!rst_in) begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic go(input int k, input int iv, input int ic, input int rv, input int rc, input int rid);
    clear_in();
    in_iv[k] = iv; in_ic[k] = ic; in_rv[k] = rv; in_rc[k] = rc; in_rid[k] = rid;
    cycle();
  endtask

  task automatic do_reset();
    clear_in();
    rst_in = 1'b1;
    cycle();
    cycle();
    rst_in = 1'b0;
  endtask

  task automatic rand_inputs(input int k);
    int c, r;
    in_iv[k] = ($urandom_range(0, 9) < 6) ? 1 : 0;
    in_ic[k] = (k == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
    c = (k == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
    r = $urandom_range(0, 9);
    in_rv[k] = 0; in_rc[k] = c; in_rid[k] = 0;
    if (r < 7) begin
      in_rv[k] = 1;
      if (c < n_chan(k) && outst(k, c) > 0)
        in_rid[k] = wrapk(k, m_comp[k][c] + 1 + int'($urandom_range(0, outst(k, c) - 1)));
      else
        in_rid[k] = $urandom_range(0, id_mod(k) - 1);
    end else if (r == 7) begin
      in_rv[k]  = 1;
      in_rid[k] = $urandom_range(0, id_mod(k) - 1);
    end
  endtask

  // Monitor: one expected snapshot per driven cycle, compared mid-cycle.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_ready", a_ready, e.a_ready);
        chk("a_issue_id", a_iid, e.a_iid);
        chk("a_retire_err", a_err, e.a_err);
        chk("a_next", a_next, e.a_next);
        chk("a_completed", a_comp, e.a_comp);
        chk("a_idle", a_idle, e.a_idle);
        chk("b_ready", b_ready, e.b_ready);
        if (e.b_chk_id) chk("b_issue_id", b_iid, e.b_iid);
        chk("b_retire_err", b_err, e.b_err);
        chk("b_next", b_next, e.b_next);
        chk("b_completed", b_comp, e.b_comp);
        chk("b_idle", b_idle, e.b_idle);
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    clear_in();
    model_reset();
    apply_inputs();

    do_reset();
    #2;
    chk("reset_next", a_next, 16'h0101);
    chk("reset_completed", a_comp, 16'h0000);
    chk("reset_idle_a", a_idle, 2'b11);
    chk("reset_idle_b", b_idle, 3'b111);

    // In-order on ch0.
    repeat (3) go(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) go(0, 0, 0, 1, 0, i);
    go(0, 0, 0, 0, 0, 0);
    #2;
    chk("inorder_completed", a_comp[7:0], 8'd3);
    chk("inorder_idle", a_idle[0], 1'b1);

    // Out-of-order on ch1.
    repeat (4) go(0, 1, 1, 0, 0, 0);
    for (int i = 4; i >= 2; i--) go(0, 0, 0, 1, 1, i);
    go(0, 0, 0, 1, 1, 1);
    repeat (4) go(0, 0, 0, 0, 0, 0);
    #2;
    chk("ooo_drain", a_comp[15:8], 8'd4);

    // Backpressure on ch0 from a fresh state.
    do_reset();
    repeat (8) go(0, 1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    #2;
    chk("full_ready_ch0", a_ready, 1'b0);
    go(0, 0, 1, 0, 0, 0);
    #2;
    chk("ready_ch1_while_ch0_full", a_ready, 1'b1);
    go(0, 1, 0, 1, 0, 1);
    #2;
    chk("ready_low_in_retire_cycle", a_ready, 1'b0);
    go(0, 1, 0, 0, 0, 0);
    #2;
    chk("ready_after_free", a_ready, 1'b1);
    chk("ninth_issue_id", a_iid, 8'd9);

    // Rejected retires.
    do_reset();
    repeat (3) go(0, 1, 0, 0, 0, 0);
    go(0, 0, 0, 1, 0, 5);
    go(0, 0, 0, 0, 0, 0);
    #2;
    chk("err_out_of_window", a_err, 1'b1);
    go(0, 0, 0, 0, 0, 0);
    #2;
    chk("err_one_cycle", a_err, 1'b0);
    go(0, 0, 0, 1, 0, 2);
    go(0, 0, 0, 1, 0, 2);
    go(0, 0, 0, 0, 0, 0);
    #2;
    chk("err_duplicate", a_err, 1'b1);
    go(1, 0, 0, 1, 3, 1);
    go(1, 0, 0, 0, 0, 0);
    #2;
    chk("err_bad_channel", b_err, 1'b1);

    // Wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      go(1, 1, 0, 0, 0, 0);
      go(1, 0, 0, 1, 0, (i + 1) % 16);
    end
    go(1, 0, 0, 0, 0, 0);
    #2;
    chk("wrap_completed", b_comp[3:0], 4'd4);
    chk("wrap_next", b_next[3:0], 4'd5);

    // Random traffic on both instances with occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      clear_in();
      rst_in = ($urandom_range(0, 499) == 0);
      rand_inputs(0);
      rand_inputs(1);
      cycle();
    end
    rst_in = 1'b0;
    clear_in();
    repeat (3) cycle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
